uart_reg_initiator: RTL

- Bus initiator that drives the UART register-file slave port (cs/wen/addr/wdata/rdata) on behalf of a host-side command stream.
- Issues single-cycle writes and reads.
- Optional poll mode re-reads a register until masked bits are non-zero or a timeout expires. Used to program CNTRL0 and wait on CNTRL1 status (data_valid, intr, fifo_status) without host busy-looping.

---
 rtl/uart_reg_pkg.sv | 34 +++
 rtl/uart_poll_timer.sv | 52 +++++
 rtl/uart_reg_initiator.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register file and its bus initiator.
package uart_reg_pkg;

  // Register offsets on the slave port
  localparam logic [3:0] CNTRL0   = 4'd0;
  localparam logic [3:0] CNTRL1   = 4'd4;
  localparam logic [3:0] DATA_REG = 4'd8;

  // CNTRL0 field positions
  localparam int C0_WORD_LEN_LSB = 0;
  localparam int C0_WORD_LEN_MSB = 4;
  localparam int C0_STOP_BIT     = 5;
  localparam int C0_OVERSAMPLE   = 6;
  localparam int C0_ENABLE       = 7;

  // CNTRL1 field positions
  localparam int C1_INTR         = 0;
  localparam int C1_DATA_VALID   = 1;
  localparam int C1_FIFO_LSB     = 2;
  localparam int C1_FIFO_MSB     = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_GAP,
    ST_RESP
  } init_state_e;

  // Slave bus address for a 4-bit register offset
  function automatic logic [31:0] reg_addr(input logic [3:0] offset);
    return {28'd0, offset};
  endfunction

endpackage

// File: rtl/uart_poll_timer.sv
// Attempt and inter-read gap counters used by the initiator's poll mode.
module uart_poll_timer
  import uart_reg_pkg::*;
#(
  parameter int POLL_TIMEOUT = 1024,
  parameter int POLL_GAP     = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic attempt_clr_i,
  input  logic attempt_inc_i,
  input  logic gap_clr_i,
  input  logic gap_inc_i,
  output logic gap_done_o,
  output logic attempt_last_o
);

  localparam int CW = $clog2(POLL_TIMEOUT + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [CW-1:0] ATT_LAST = CW'(POLL_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  logic [CW-1:0] attempt_q, attempt_d;
  logic [GW-1:0] gap_q, gap_d;

  // Next-count logic: clear takes priority over increment
  always_comb begin
    attempt_d = attempt_q;
    gap_d     = gap_q;
    if (attempt_clr_i)      attempt_d = '0;
    else if (attempt_inc_i) attempt_d = attempt_q + CW'(1);
    if (gap_clr_i)          gap_d = '0;
    else if (gap_inc_i)     gap_d = gap_q + GW'(1);
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      attempt_q <= '0;
      gap_q     <= '0;
    end else begin
      attempt_q <= attempt_d;
      gap_q     <= gap_d;
    end
  end

  // The read being sampled now is the final allowed attempt
  assign attempt_last_o = (attempt_q == ATT_LAST);
  // Last idle cycle of the gap; the next cycle is a new access
  assign gap_done_o     = (gap_q == GAP_LAST);

endmodule

// File: rtl/uart_reg_initiator.sv
// Register-bus initiator: single writes/reads and read-poll on the UART slave.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | cmd_ready=1, waiting for a command
//  ST_ACCESS | cs=1 for this single cycle; slave captures / rdata sampled
//  ST_GAP    | poll only: cs=0 for POLL_GAP cycles before the next read
//  ST_RESP   | rsp_valid=1, response held until rsp_ready
module uart_reg_initiator
  import uart_reg_pkg::*;
#(
  parameter int POLL_TIMEOUT = 1024,
  parameter int POLL_GAP     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_poll,
  input  logic [3:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        cs,
  output logic        wen,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  init_state_e state_q, state_d;
  logic        cs_q, cs_d, wen_q, wen_d, poll_q, poll_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, mask_q, mask_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        att_clr, att_inc, gap_clr, gap_inc, gap_done, att_last;
  logic        hit;

  uart_poll_timer #(
    .POLL_TIMEOUT(POLL_TIMEOUT),
    .POLL_GAP    (POLL_GAP)
  ) u_timer (
    .clk           (clk),
    .reset_n       (reset_n),
    .attempt_clr_i (att_clr),
    .attempt_inc_i (att_inc),
    .gap_clr_i     (gap_clr),
    .gap_inc_i     (gap_inc),
    .gap_done_o    (gap_done),
    .attempt_last_o(att_last)
  );

  assign hit = (rdata & mask_q) != 32'd0;

  // Next state, next bus drive and response capture
  always_comb begin
    state_d       = state_q;
    cs_d          = cs_q;
    wen_d         = wen_q;
    poll_d        = poll_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    att_clr       = 1'b0;
    att_inc       = 1'b0;
    gap_clr       = 1'b0;
    gap_inc       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cs_d    = 1'b1;
          wen_d   = cmd_write;
          addr_d  = reg_addr(cmd_addr);
          wdata_d = cmd_write ? cmd_wdata : 32'd0;
          mask_d  = cmd_mask;
          // A zero mask could never match, so it degrades to a plain read
          poll_d  = cmd_poll && !cmd_write && (cmd_mask != 32'd0);
          att_clr = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cs_d  = 1'b0;
        wen_d = 1'b0;
        if (wen_q) begin
          rsp_rdata_d   = 32'd0;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if (!poll_q || hit) begin
          att_inc       = poll_q;
          rsp_rdata_d   = rdata;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if (att_last) begin
          att_inc       = 1'b1;
          rsp_rdata_d   = rdata;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          att_inc = 1'b1;
          gap_clr = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_inc = 1'b1;
        if (gap_done) begin
          cs_d    = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cs_q          <= 1'b0;
      wen_q         <= 1'b0;
      poll_q        <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      mask_q        <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_q          <= cs_d;
      wen_q         <= wen_d;
      poll_q        <= poll_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      mask_q        <= mask_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign cs          = cs_q;
  assign wen         = wen_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
